// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: per-source level/edge capture with queued-edge counting,
// claim/complete tracking, and masked priority vectors for the per-target selector.

module plic_gateway_src #(
    parameter int MAX_PENDING_COUNT = 8,
    parameter int PENDCNT_BITS      = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_i,
    input  logic el_i,
    input  logic claim_sel_i,
    input  logic complete_sel_i,
    output logic ip_o
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CLAIMED = 2'd2
    } state_e;

    localparam logic [PENDCNT_BITS-1:0] CNT_MAX = PENDCNT_BITS'(MAX_PENDING_COUNT);

    state_e                  state_q, state_d;
    logic [PENDCNT_BITS-1:0] cnt_q, cnt_d;
    logic                    src_q;
    logic                    rise, claim_hit, complete_hit, cnt_sat;

    assign rise         = src_i & ~src_q;
    assign claim_hit    = claim_sel_i & (state_q == PENDING);
    assign complete_hit = complete_sel_i & (state_q == CLAIMED);
    assign cnt_sat      = (cnt_q >= CNT_MAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!el_i) begin
            cnt_d = '0;
            case (state_q)
                IDLE:    if (src_i)        state_d = PENDING;
                PENDING: if (claim_hit)    state_d = CLAIMED;
                CLAIMED: if (complete_hit) state_d = IDLE;
                default:                   state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: if (rise) state_d = PENDING;
                PENDING: begin
                    if (claim_hit)         state_d = CLAIMED;
                    if (rise && !cnt_sat)  cnt_d   = cnt_q + 1'b1;
                end
                CLAIMED: begin
                    if (complete_hit) begin
                        // A coincident edge takes the slot of the retiring one: count unchanged.
                        if (rise) begin
                            state_d = PENDING;
                        end else if (cnt_q != '0) begin
                            state_d = PENDING;
                            cnt_d   = cnt_q - 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (rise && !cnt_sat) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ip_o = (state_q == PENDING);
endmodule

module plic_gateway #(
    parameter int SOURCES           = 8,
    parameter int PRIORITIES        = 7,
    parameter int SOURCES_BITS      = 3,
    parameter int PRIORITY_BITS     = 3,
    parameter int MAX_PENDING_COUNT = 8,
    parameter int PENDCNT_BITS      = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [SOURCES-1:0]                      src_i,
    input  logic [SOURCES-1:0]                      el_i,
    input  logic [SOURCES-1:0]                      ie_i,
    input  logic [SOURCES-1:0][PRIORITY_BITS-1:0]   priority_i,
    input  logic                                    claim_i,
    input  logic [SOURCES_BITS-1:0]                 claim_id_i,
    input  logic                                    complete_i,
    input  logic [SOURCES_BITS-1:0]                 complete_id_i,
    output logic [SOURCES-1:0]                      ip_o,
    output logic [SOURCES-1:0][SOURCES_BITS-1:0]    id_o,
    output logic [SOURCES-1:0][PRIORITY_BITS-1:0]   priority_o
);
    if (PRIORITIES > (2**PRIORITY_BITS) - 1 || MAX_PENDING_COUNT > (2**PENDCNT_BITS) - 1 ||
        SOURCES > 2**SOURCES_BITS) begin : g_cfg_err
        $error("plic_gateway: inconsistent parameter widths");
    end

    for (genvar s = 0; s < SOURCES; s++) begin : g_src
        logic claim_sel, complete_sel;

        // Strobes are decoded here; each source qualifies them with its own state.
        assign claim_sel    = claim_i    & (claim_id_i    == SOURCES_BITS'(s));
        assign complete_sel = complete_i & (complete_id_i == SOURCES_BITS'(s));

        plic_gateway_src #(
            .MAX_PENDING_COUNT (MAX_PENDING_COUNT),
            .PENDCNT_BITS      (PENDCNT_BITS)
        ) u_src (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .src_i          (src_i[s]),
            .el_i           (el_i[s]),
            .claim_sel_i    (claim_sel),
            .complete_sel_i (complete_sel),
            .ip_o           (ip_o[s])
        );

        assign id_o[s]       = SOURCES_BITS'(s);
        assign priority_o[s] = (ip_o[s] & ie_i[s]) ? priority_i[s] : '0;
    end
endmodule

// File: tb/tb_plic_gateway.sv
// Bench for plic_gateway: directed scenarios plus random traffic against a
// token-count model of outstanding interrupts per source.

module tb_plic_gateway;
    localparam int NS  = 8;
    localparam int MAX = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       src = '0, el = '0, ie = '0;
    logic [7:0][2:0]  prio = '0;
    logic             claim = 1'b0, comp = 1'b0;
    logic [2:0]       claim_id = '0, comp_id = '0;
    logic [7:0]       ip_o;
    logic [7:0][2:0]  id_o, priority_o;

    int checks = 0, failures = 0;
    // Model: tok = outstanding interrupts incl. the one in service; clm = in service.
    int tok [NS];
    bit clm [NS];
    bit sp  [NS];

    plic_gateway dut (
        .clk_i(clk), .rst_i(rst), .src_i(src), .el_i(el), .ie_i(ie), .priority_i(prio),
        .claim_i(claim), .claim_id_i(claim_id), .complete_i(comp), .complete_id_i(comp_id),
        .ip_o(ip_o), .id_o(id_o), .priority_o(priority_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin tok[s] = 0; clm[s] = 0; sp[s] = 0; end
    endtask

    task automatic model_tick();
        for (int s = 0; s < NS; s++) begin
            bit rise, pend, chit, xhit;
            rise = src[s] & ~sp[s];
            pend = (tok[s] > 0) && !clm[s];
            chit = claim && (int'(claim_id) == s) && pend;
            xhit = comp && (int'(comp_id) == s) && clm[s];
            if (el[s]) begin
                if (xhit) begin clm[s] = 0; tok[s]--; end
                if (chit) clm[s] = 1;
                if (rise) tok[s] = (tok[s] + 1 > MAX + 1) ? MAX + 1 : tok[s] + 1;
            end else begin
                if (xhit) begin clm[s] = 0; tok[s] = 0; end
                else if (chit) clm[s] = 1;
                else if (tok[s] == 0 && src[s]) tok[s] = 1;
                if (tok[s] > 1) tok[s] = 1;
            end
            sp[s] = src[s];
        end
    endtask

    function automatic logic [7:0] exp_ip();
        logic [7:0] r = '0;
        for (int s = 0; s < NS; s++) r[s] = (tok[s] > 0) && !clm[s];
        return r;
    endfunction

    function automatic logic [7:0][2:0] exp_prio();
        logic [7:0][2:0] r = '0;
        for (int s = 0; s < NS; s++) if (tok[s] > 0 && !clm[s] && ie[s]) r[s] = prio[s];
        return r;
    endfunction

    task automatic step(input string tag);
        @(posedge clk);
        model_tick();
        #1;
        chk({tag, "_ip"},   32'(ip_o),       32'(exp_ip()));
        chk({tag, "_prio"}, 32'(priority_o), 32'(exp_prio()));
    endtask

    task automatic pulse(input int s, input string tag);
        src[s] = 1'b1; step(tag);
        src[s] = 1'b0; step(tag);
    endtask

    task automatic do_claim(input int id, input string tag);
        claim = 1'b1; claim_id = 3'(id); step(tag); claim = 1'b0;
    endtask

    task automatic do_comp(input int id, input string tag);
        comp = 1'b1; comp_id = 3'(id); step(tag); comp = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();
        ie = 8'hFF;
        for (int s = 0; s < NS; s++) prio[s] = 3'($urandom_range(1, 7));
        #1;
        chk("reset_ip",   32'(ip_o),       32'h0);
        chk("reset_prio", 32'(priority_o), 32'h0);
        chk("id_const",   32'(id_o), 32'({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
        @(negedge clk); rst = 1'b0;

        // Level source: pends one cycle after sampling, holds after drop
        src[3] = 1'b1;
        chk("lvl_pre", 32'(ip_o[3]), 32'h0);
        step("lvl_rise");  chk("lvl_ip3", 32'(ip_o[3]), 32'h1);
        src[3] = 1'b0;
        step("lvl_drop");  chk("lvl_hold", 32'(ip_o[3]), 32'h1);
        do_claim(3, "lvl_claim"); chk("lvl_claimed", 32'(ip_o[3]), 32'h0);
        do_comp(3, "lvl_comp");   step("lvl_after");
        chk("lvl_idle", 32'(ip_o[3]), 32'h0);

        // Edge queue: three pulses give two re-pends after the first service
        el[5] = 1'b1;
        repeat (3) pulse(5, "eq_pulse");
        chk("eq_pend", 32'(ip_o[5]), 32'h1);
        n = 0;
        repeat (4) begin
            do_claim(5, "eq_claim");
            do_comp(5, "eq_comp");
            if (ip_o[5]) n++;
        end
        chk("eq_repend_count", 32'(n), 32'd2);
        chk("eq_final", 32'(ip_o[5]), 32'h0);

        // Saturation: 12 edges while claimed keep only 8
        el[1] = 1'b1;
        pulse(1, "sat_first");
        do_claim(1, "sat_claim0");
        repeat (12) pulse(1, "sat_pulse");
        n = 0;
        repeat (10) begin
            do_comp(1, "sat_comp");
            if (ip_o[1]) n++;
            do_claim(1, "sat_claim");
        end
        chk("sat_count", 32'(n), 32'd8);
        chk("sat_final", 32'(ip_o[1]), 32'h0);

        // Masking: disabled source still pends; priority shows when enabled
        ie[2] = 1'b0; prio[2] = 3'd5; src[2] = 1'b1;
        step("mask_pend");
        chk("mask_ip2",   32'(ip_o[2]),       32'h1);
        chk("mask_prio2", 32'(priority_o[2]), 32'h0);
        ie[2] = 1'b1; #1;
        chk("mask_on", 32'(priority_o[2]), 32'd5);
        src[2] = 1'b0;
        step("mask_drop");

        // Ignored operations and simultaneous claim/complete
        src[4] = 1'b1; step("ill_p4"); src[4] = 1'b0;
        do_comp(4, "ill_comp4");  chk("ill_comp4_kept", 32'(ip_o[4]), 32'h1);
        do_claim(6, "ill_claim6"); step("ill_after6");
        chk("ill_claim6_idle", 32'(ip_o[6]), 32'h0);
        src[0] = 1'b1; step("ill_p0"); src[0] = 1'b0;
        do_claim(0, "ill_claim0");
        src[3] = 1'b1; step("ill_p3"); src[3] = 1'b0;
        claim = 1'b1; claim_id = 3'd3; comp = 1'b1; comp_id = 3'd0;
        step("both"); claim = 1'b0; comp = 1'b0;
        chk("both_claim3", 32'(ip_o[3]), 32'h0);
        src[0] = 1'b1; step("both_repend0"); src[0] = 1'b0;
        chk("both_comp0", 32'(ip_o[0]), 32'h1);

        // Asynchronous reset mid-claim with queued edges
        el[7] = 1'b1;
        repeat (3) pulse(7, "rst_pulse");
        do_claim(7, "rst_claim");
        #2; rst = 1'b1; #1;
        model_reset();
        chk("rst_async_ip",   32'(ip_o),       32'h0);
        chk("rst_async_prio", 32'(priority_o), 32'h0);
        src = '0; src[6] = 1'b1; el[6] = 1'b0;
        @(negedge clk); rst = 1'b0;
        step("rst_rel");
        chk("rst_rel_ip6", 32'(ip_o[6]), 32'h1);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int s = 0; s < NS; s++) if ($urandom_range(0, 3) == 0) src[s] = ~src[s];
            if ($urandom_range(0, 15) == 0) el = 8'($urandom);
            if ($urandom_range(0, 15) == 0) ie = 8'($urandom);
            if ($urandom_range(0, 7) == 0) prio[$urandom_range(0, 7)] = 3'($urandom_range(0, 7));
            claim = 1'($urandom_range(0, 1)); claim_id = 3'($urandom_range(0, 7));
            comp  = 1'($urandom_range(0, 1)); comp_id  = 3'($urandom_range(0, 7));
            if (c == 700) begin
                rst = 1'b1; #1; model_reset();
                chk("rand_rst_ip", 32'(ip_o), 32'h0);
                @(negedge clk); rst = 1'b0;
            end
            step("rand");
        end
        claim = 1'b0; comp = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/plic_gateway.md
Name: plic_gateway

Overview:
- Per-source interrupt gateway and pending-state array for the PLIC.
- Sits directly upstream of the per-target priority selector.
- Converts raw level- or edge-triggered source lines into pending bits and tracks claim/complete per source.
- Drives the per-source id and masked priority vectors that the selector compares against the target threshold.

Parameters:
SOURCES, 8, number of interrupt sources
PRIORITIES, 7, highest legal priority value
SOURCES_BITS, 3, width of a source id (log2 SOURCES)
PRIORITY_BITS, 3, width of a priority value
MAX_PENDING_COUNT, 8, saturation limit of the per-source queued-edge counter
PENDCNT_BITS, 4, counter width; must hold MAX_PENDING_COUNT

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
src_i  in  SOURCES  raw interrupt lines, synchronous to clk_i
el_i  in  SOURCES  per-source mode: 1=edge, 0=level
ie_i  in  SOURCES  per-source enable for this target
priority_i  in  PRIORITY_BITS x SOURCES (array)  configured priority per source
claim_i  in  1  claim strobe, one cycle
claim_id_i  in  SOURCES_BITS  id being claimed
complete_i  in  1  complete strobe, one cycle
complete_id_i  in  SOURCES_BITS  id being completed
ip_o  out  SOURCES  registered pending bits
id_o  out  SOURCES_BITS x SOURCES (array)  constant: id_o[s] = s
priority_o  out  PRIORITY_BITS x SOURCES (array)  priority_i[s] if ip_o[s] & ie_i[s], else 0

Behaviour:
- Decided: one clock clk_i; rst_i is asynchronous and active-high.
- Reset values: all sources IDLE, counters 0, src_q 0, ip_o 0, so priority_o is all zero.
- Each source has a 3-state FSM: IDLE, PENDING, CLAIMED. ip_o[s] = (state==PENDING), registered.
- src_q[s] is a register of src_i[s]. Rising edge: rise[s] = src_i[s] & ~src_q[s].
- Level mode (el_i[s]=0):
  - IDLE & src_i[s] -> PENDING. ip_o rises one cycle after src_i is sampled high.
  - PENDING is held even if src_i drops.
  - PENDING & claim hit -> CLAIMED.
  - CLAIMED & complete hit -> IDLE. If src_i is still high, the source re-pends on the next edge (one IDLE cycle).
  - Counter is forced to 0 in this mode.
- Edge mode (el_i[s]=1):
  - IDLE & rise -> PENDING.
  - rise while PENDING or CLAIMED -> cnt++, saturating at MAX_PENDING_COUNT; further edges are dropped.
  - CLAIMED & complete & cnt>0 -> PENDING, cnt--.
  - CLAIMED & complete & cnt==0 -> IDLE.
  - Simultaneous rise & complete, cnt==0 -> PENDING, cnt stays 0.
  - Simultaneous rise & complete, cnt>0 -> PENDING, cnt unchanged.
  - Simultaneous rise & complete, cnt==MAX -> PENDING, cnt = MAX-1+1 = MAX.
- Claim hit: claim_i & claim_id_i==s & state==PENDING. Claims to a non-PENDING or out-of-range id are ignored.
- Complete hit: complete_i & complete_id_i==s & state==CLAIMED. Any other complete is ignored.
- claim and complete in the same cycle act independently.
  - Same id in PENDING: claim acts, complete ignored.
  - Same id in CLAIMED: complete acts, claim ignored.
- ie_i masks priority_o only. A disabled source still pends, and its priority appears the cycle ie_i rises.
- el_i change mid-operation: FSM state is kept. Switching to level clears cnt that cycle.
- A source high at reset release is seen as a rising edge (src_q=0) and pends on the first clock edge.
- priority_o and id_o are combinational from registered state and inputs. Latency source->priority_o = 1 cycle.
- Reset asserted mid-operation discards all pending, claimed and queued state immediately.

Test Plan:
- Level: src_i[3]=1 at cycle 0 -> ip_o[3]=1 at cycle 1. Drop src; ip_o[3] stays 1. claim id 3 -> ip_o[3]=0. complete id 3 -> stays idle.
- Edge queue: el_i[5]=1, three pulses on src_i[5] before claim -> claim/complete repeated; ip_o[5] re-asserts exactly 2 more times, then stays 0.
- Saturation: el_i[1]=1, 12 edges while CLAIMED -> exactly 8 further pend/claim cycles; the 9th complete leaves ip_o[1]=0.
- Masking: ie_i[2]=0, priority_i[2]=5, source pends -> ip_o[2]=1, priority_o[2]=0. Set ie_i[2]=1 -> priority_o[2]=5 same cycle.
- Illegal ops: complete id 4 while PENDING and claim id 6 while IDLE -> no state change. Same-cycle claim id 3 (PENDING) with complete id 0 (CLAIMED) -> both act.
- Reset: assert rst_i mid-claim with cnt=2 -> ip_o=0, priority_o all 0 asynchronously. After release, a level-high source pends on the first clock edge.
